// File: rtl/fir_out_quantizer_if.sv
// fir_out_quantizer_if: accumulator input, sample stream output and status of the FIR output stage
interface fir_out_quantizer_if #(
  parameter int IN_WIDTH  = 38,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 3
);
  logic [IN_WIDTH-1:0]  acc_in;
  logic                 acc_valid;
  logic [OUT_WIDTH-1:0] q_out;
  logic                 q_valid;
  logic                 q_ready;
  logic [CNT_WIDTH-1:0] fifo_count;
  logic                 drop;
  logic                 sat_flag;
  logic                 overrun_flag;
  modport master (
    output acc_in, acc_valid, q_ready,
    input  q_out, q_valid, fifo_count, drop, sat_flag, overrun_flag
  );
  modport slave (
    input  acc_in, acc_valid, q_ready,
    output q_out, q_valid, fifo_count, drop, sat_flag, overrun_flag
  );
endinterface

// File: rtl/fir_out_quantizer.sv
// fir_out_quantizer: round, saturate and buffer FIR accumulator results for a valid/ready consumer
module fir_out_quantizer #(
  parameter int IN_WIDTH   = 38,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input logic clk,
  input logic reset,
  fir_out_quantizer_if.slave bus
);
  localparam int RW = IN_WIDTH + 1 - SHIFT;
  localparam int EW = RW > OUT_WIDTH ? RW : OUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [EW-1:0] SMAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  logic signed [IN_WIDTH:0] sum;
  logic signed [EW-1:0]     r_ext;
  logic [RW-1:0]            r_d, r_q;
  logic                     valid_r_d, valid_r_q;
  logic [OUT_WIDTH-1:0]     s_d, s_q;
  logic                     valid_s_d, valid_s_q, sat_d, sat_q;
  logic [OUT_WIDTH-1:0]     mem_d [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_d, wr_q, rd_d, rd_q;
  logic [CNT_WIDTH-1:0]     cnt_d, cnt_q, left;
  logic [OUT_WIDTH-1:0]     q_out_d, q_out_q;
  logic                     q_valid_d, q_valid_q, drop_d, drop_q;
  logic                     sat_flag_d, sat_flag_q, overrun_d, overrun_q;
  logic                     pop, push, full, hi, lo;
  // round half toward +inf, then clip the rounded value to the output range
  always_comb begin
    sum = $signed({bus.acc_in[IN_WIDTH-1], bus.acc_in}) + $signed({{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1));
    r_d = RW'(sum >>> SHIFT);
    valid_r_d = bus.acc_valid;
    r_ext = EW'($signed(r_q));
    hi = r_ext > SMAX;
    lo = r_ext < SMIN;
    s_d = hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : r_ext[OUT_WIDTH-1:0];
    sat_d = hi || lo;
    valid_s_d = valid_r_q;
    sat_flag_d = sat_flag_q || (valid_r_q && sat_d);
  end
  // FIFO bookkeeping; q_out looks ahead to the head that will exist after this edge
  always_comb begin
    pop = q_valid_q && bus.q_ready;
    full = cnt_q == CNT_WIDTH'(FIFO_DEPTH);
    push = valid_s_q && (!full || pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = s_q;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    left = cnt_q - CNT_WIDTH'(pop);
    q_out_d = left != '0 ? mem_q[rd_d] : push ? s_q : q_out_q;
    q_valid_d = cnt_d != '0;
    drop_d = valid_s_q && full && !pop;
    overrun_d = overrun_q || drop_d;
  end
  // pipeline, pointers and flags with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
      valid_r_q <= 1'b0;
      s_q <= '0;
      valid_s_q <= 1'b0;
      sat_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      q_out_q <= '0;
      q_valid_q <= 1'b0;
      drop_q <= 1'b0;
      sat_flag_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      r_q <= r_d;
      valid_r_q <= valid_r_d;
      s_q <= s_d;
      valid_s_q <= valid_s_d;
      sat_q <= sat_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      q_out_q <= q_out_d;
      q_valid_q <= q_valid_d;
      drop_q <= drop_d;
      sat_flag_q <= sat_flag_d;
      overrun_q <= overrun_d;
    end
  end
  // sample storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
  assign bus.q_out        = q_out_q;
  assign bus.q_valid      = q_valid_q;
  assign bus.fifo_count   = cnt_q;
  assign bus.drop         = drop_q;
  assign bus.sat_flag     = sat_flag_q;
  assign bus.overrun_flag = overrun_q;
endmodule
